// File: rtl/crc_engine_param.sv
// Memory-mapped CRC engine with programmable width, polynomial, input/output transposes and a
// multi-cycle datapath. Define CRC_STATUS_EN to build the STATUS register (busy, sticky OVR, word count).
module crc_engine_param #(
    parameter logic [31:0] BASE_ADDR      = 32'h4003_2000,
    parameter int unsigned MAX_WIDTH      = 32,
    parameter int unsigned BITS_PER_CYCLE = 8,
    parameter logic [31:0] RESET_POLY     = 32'h0000_1021
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel,
    input  logic        rw,
    input  logic [31:0] addr,
    input  logic [31:0] data_wr,
    output logic [31:0] data_rd,
    output logic        rd_valid,
    output logic        busy,
    output logic        done
);

    localparam int unsigned    TW       = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam int             BPC_I    = int'(BITS_PER_CYCLE);
    localparam logic [5:0]     BPC      = 6'(BITS_PER_CYCLE);
    localparam logic [5:0]     MAXW     = 6'(MAX_WIDTH);
    localparam logic [MAX_WIDTH-1:0] ONES = '1;
    localparam logic [31:0]    CTRL_RST = 32'h000F_0000;
    localparam logic [1:0]     OFF_DATA   = 2'd0;
    localparam logic [1:0]     OFF_POLY   = 2'd1;
    localparam logic [1:0]     OFF_CTRL   = 2'd2;
    localparam logic [1:0]     OFF_STATUS = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // 00 none, 01 bits within bytes, 10 bits and bytes, 11 bytes only
    function automatic logic [31:0] transpose(input logic [31:0] x, input logic [1:0] mode);
        logic [31:0] y;
        y = x;
        for (int i = 0; i < 32; i++) begin
            case (mode)
                2'b01:   y[i] = x[(i & ~7) + 7 - (i & 7)];
                2'b10:   y[i] = x[31 - i];
                2'b11:   y[i] = x[24 - (i & ~7) + (i & 7)];
                default: y[i] = x[i];
            endcase
        end
        return y;
    endfunction

    function automatic logic [5:0] crc_width(input logic [4:0] wsel);
        logic [5:0] w;
        w = 6'(wsel) + 6'd1;
        if (w < 6'd8) begin
            w = 6'd8;
        end else if (w > MAXW) begin
            w = MAXW;
        end
        return w;
    endfunction

    function automatic logic [MAX_WIDTH-1:0] width_mask(input logic [5:0] w);
        return ONES >> (MAXW - w);
    endfunction

    function automatic logic [5:0] data_len(input logic [1:0] dsz);
        return dsz[1] ? 6'd32 : (dsz[0] ? 6'd16 : 6'd8);
    endfunction

    // Up to BITS_PER_CYCLE serial LFSR steps, MSB of din first, gated by bits remaining.
    function automatic logic [MAX_WIDTH-1:0] crc_run(
        input logic [MAX_WIDTH-1:0] crc_in,
        input logic [31:0]          din,
        input logic [5:0]           rem,
        input logic [TW-1:0]        top,
        input logic [MAX_WIDTH-1:0] msk,
        input logic [MAX_WIDTH-1:0] pol
    );
        logic [MAX_WIDTH-1:0] c;
        logic                 fb;
        c = crc_in & msk;
        for (int i = 0; i < BPC_I; i++) begin
            if (6'(i) < rem) begin
                fb = c[top] ^ din[31 - i];
                c  = (c << 1) & msk;
                if (fb) begin
                    c = c ^ pol;
                end
            end
        end
        return c;
    endfunction

    state_t               state_q;
    state_t               state_d;
    logic                 busy_d;
    logic                 done_d;
    logic [MAX_WIDTH-1:0] crc_q;
    logic [MAX_WIDTH-1:0] crc_out;
    logic [MAX_WIDTH-1:0] poly_q;
    logic [31:0]          ctrl_q;
    logic [31:0]          din_q;
    logic [5:0]           rem_q;
    logic [TW-1:0]        top_q;
    logic [MAX_WIDTH-1:0] mask_q;
    logic [MAX_WIDTH-1:0] pmask_q;
    logic [MAX_WIDTH-1:0] crc_step;

    logic [31:0]          rel;
    logic                 hit;
    logic [1:0]           off;
    logic                 wr_hit;
    logic                 wr_acc;
    logic                 rd_acc;
    logic                 start;
    logic                 seed;
    logic                 last;
    logic [5:0]           w_cur;
    logic [5:0]           len_cur;
    logic [MAX_WIDTH-1:0] mask_cur;
    logic [MAX_WIDTH-1:0] fx_mask;
    logic [31:0]          status;
    logic [31:0]          rd_val;

    // Address window decode; anything misaligned or beyond STATUS is unmapped.
    assign rel    = addr - BASE_ADDR;
    assign hit    = (rel[31:4] == 28'd0) && (rel[1:0] == 2'd0);
    assign off    = rel[3:2];
    assign wr_hit = sel & rw & hit;
    assign wr_acc = wr_hit & (state_q == IDLE);
    assign rd_acc = sel & ~rw;

    assign w_cur    = crc_width(ctrl_q[20:16]);
    assign len_cur  = data_len(ctrl_q[23:22]);
    assign mask_cur = width_mask(w_cur);
    assign fx_mask  = ctrl_q[26] ? mask_cur : '0;

    assign start = wr_acc && (off == OFF_DATA) && !ctrl_q[25];
    assign seed  = wr_acc && (off == OFF_DATA) &&  ctrl_q[25];
    assign last  = (rem_q <= BPC);

    assign crc_step = crc_run(crc_q, din_q, rem_q, top_q, mask_q, pmask_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // done is raised for the final RUN cycle of each word.
    always_comb begin
        busy_d = (state_d == RUN);
        done_d = 1'b0;
        if ((state_q == IDLE) && start) begin
            done_d = (len_cur <= BPC);
        end else if ((state_q == RUN) && !last) begin
            done_d = ((rem_q - BPC) <= BPC);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q   <= ONES;
            crc_out <= ONES;
            poly_q  <= MAX_WIDTH'(RESET_POLY);
            ctrl_q  <= CTRL_RST;
            din_q   <= '0;
            rem_q   <= '0;
            top_q   <= '0;
            mask_q  <= '0;
            pmask_q <= '0;
        end else begin
            if (wr_acc && (off == OFF_POLY)) begin
                poly_q <= MAX_WIDTH'(data_wr);
            end
            if (wr_acc && (off == OFF_CTRL)) begin
                ctrl_q <= data_wr;
            end
            if (seed) begin
                crc_q   <= MAX_WIDTH'(transpose(data_wr, ctrl_q[31:30])) & mask_cur;
                crc_out <= MAX_WIDTH'(transpose(data_wr, ctrl_q[31:30])) & mask_cur;
            end
            // Configuration is frozen at word start; input is left-aligned so bit 31 goes first.
            if (start) begin
                din_q   <= transpose(data_wr, ctrl_q[31:30]) << (6'd32 - len_cur);
                rem_q   <= len_cur;
                top_q   <= TW'(w_cur - 6'd1);
                mask_q  <= mask_cur;
                pmask_q <= poly_q & mask_cur;
            end else if (state_q == RUN) begin
                crc_q <= crc_step;
                din_q <= din_q << BPC;
                rem_q <= last ? 6'd0 : (rem_q - BPC);
                if (last) begin
                    crc_out <= crc_step;
                end
            end
        end
    end

`ifdef CRC_STATUS_EN
    logic        ovr_q;
    logic [15:0] wcnt_q;
    logic        wr_drop;
    logic        stat_wr;

    assign wr_drop = wr_hit & (state_q == RUN);
    assign stat_wr = wr_acc && (off == OFF_STATUS);

    // Sets take priority over software clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_q  <= 1'b0;
            wcnt_q <= '0;
        end else begin
            if (wr_drop) begin
                ovr_q <= 1'b1;
            end else if (stat_wr && data_wr[1]) begin
                ovr_q <= 1'b0;
            end
            if ((state_q == RUN) && last) begin
                wcnt_q <= wcnt_q + 16'd1;
            end else if (stat_wr && data_wr[2]) begin
                wcnt_q <= '0;
            end
        end
    end

    assign status = {wcnt_q, 14'd0, ovr_q, busy};
`else
    assign status = 32'd0;
`endif

    always_comb begin
        rd_val = 32'd0;
        if (hit) begin
            case (off)
                OFF_DATA: rd_val = transpose(32'((crc_out ^ fx_mask) & mask_cur), ctrl_q[29:28]);
                OFF_POLY: rd_val = 32'(poly_q);
                OFF_CTRL: rd_val = ctrl_q;
                default:  rd_val = status;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_rd  <= 32'd0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
                data_rd <= rd_val;
            end
        end
    end

endmodule

// File: tb/tb_crc_engine_param.sv
// Self-checking bench for crc_engine_param: catalogue CRC vectors plus randomized configurations
// checked against a bit-serial arithmetic model of the register block.
`timescale 1ns/1ps
module tb_crc_engine_param;

    localparam logic [31:0] BASE   = 32'h4003_2000;
    localparam int          MAXW   = 32;
    localparam int          BPC    = 8;
    localparam logic [31:0] A_DATA = BASE;
    localparam logic [31:0] A_POLY = BASE + 32'h4;
    localparam logic [31:0] A_CTRL = BASE + 32'h8;
    localparam logic [31:0] A_STAT = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        rw = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] data_wr = 32'd0;
    logic [31:0] data_rd;
    logic        rd_valid;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_crc;
    logic [31:0] m_poly;
    logic [31:0] m_ctrl;
    logic        m_ovr;
    logic [15:0] m_cnt;

    crc_engine_param #(
        .BASE_ADDR(BASE),
        .MAX_WIDTH(MAXW),
        .BITS_PER_CYCLE(BPC),
        .RESET_POLY(32'h0000_1021)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sel(sel),
        .rw(rw),
        .addr(addr),
        .data_wr(data_wr),
        .data_rd(data_rd),
        .rd_valid(rd_valid),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_tr(input logic [31:0] x, input logic [1:0] t);
        logic [31:0] r;
        logic [7:0]  b;
        logic [7:0]  rb;
        r = x;
        case (t)
            2'b00: r = x;
            2'b01: for (int k = 0; k < 4; k++) begin
                       b  = x[8*k +: 8];
                       rb = {<<{b}};
                       r[8*k +: 8] = rb;
                   end
            2'b10: r = {<<{x}};
            default: r = {<<8{x}};
        endcase
        return r;
    endfunction

    function automatic int m_width(input logic [31:0] c);
        int w;
        w = int'(c[20:16]) + 1;
        if (w < 8) w = 8;
        if (w > MAXW) w = MAXW;
        return w;
    endfunction

    function automatic logic [31:0] m_mask(input int w);
        return 32'((64'd1 << w) - 64'd1);
    endfunction

    function automatic int m_len(input logic [31:0] c);
        return c[23] ? 32 : (c[22] ? 16 : 8);
    endfunction

    function automatic logic [31:0] m_crc_calc(input logic [31:0] crc, input logic [31:0] poly,
                                               input int w, input logic [31:0] din, input int len);
        longint unsigned c, msk, p, bin;
        msk = (64'd1 << w) - 64'd1;
        c   = {32'd0, crc} & msk;
        p   = {32'd0, poly} & msk;
        bin = {32'd0, din};
        for (int i = len - 1; i >= 0; i--) begin
            if ((((c >> (w - 1)) ^ (bin >> i)) & 64'd1) != 0) c = ((c << 1) & msk) ^ p;
            else c = (c << 1) & msk;
        end
        return c[31:0];
    endfunction

    function automatic logic [31:0] m_read_data();
        logic [31:0] msk;
        msk = m_mask(m_width(m_ctrl));
        return m_tr((m_crc ^ (m_ctrl[26] ? msk : 32'd0)) & msk, m_ctrl[29:28]);
    endfunction

    function automatic logic [31:0] m_status();
`ifdef CRC_STATUS_EN
        return {m_cnt, 14'd0, m_ovr, 1'b0};
`else
        return 32'd0;
`endif
    endfunction

    task automatic m_reset();
        m_crc  = 32'hFFFF_FFFF;
        m_poly = 32'h0000_1021;
        m_ctrl = 32'h000F_0000;
        m_ovr  = 1'b0;
        m_cnt  = 16'd0;
    endtask

    // ---------------- bus helpers ----------------
    task automatic bus_cycle(input logic [31:0] a, input logic w, input logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; rw = w; addr = a; data_wr = d;
        @(negedge clk);
        sel = 1'b0; rw = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus_cycle(a, 1'b0, 32'd0);
        check({tag, "_rdv"}, 32'(rd_valid), 32'd1);
        check(tag, data_rd, exp);
    endtask

    task automatic wait_idle(output int nb, output int nd, output logic last_done);
        int guard;
        nb = 0; nd = 0; last_done = 1'b0; guard = 0;
        while (busy && guard < 200) begin
            nb++;
            if (done) nd++;
            last_done = done;
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("busy_timeout", 32'd1, 32'd0);
        check("done_after_idle", 32'(done), 32'd0);
    endtask

    task automatic wr_poly(input logic [31:0] v);
        bus_cycle(A_POLY, 1'b1, v);
        m_poly = v;
    endtask

    task automatic wr_ctrl(input logic [31:0] v);
        bus_cycle(A_CTRL, 1'b1, v);
        m_ctrl = v;
    endtask

    task automatic wr_data(input logic [31:0] v);
        int   nb, nd, len;
        logic ld;
        len = m_len(m_ctrl);
        bus_cycle(A_DATA, 1'b1, v);
        if (m_ctrl[25]) begin
            m_crc = m_tr(v, m_ctrl[31:30]) & m_mask(m_width(m_ctrl));
            check("seed_no_busy", 32'(busy), 32'd0);
        end else begin
            m_crc = m_crc_calc(m_crc, m_poly, m_width(m_ctrl), m_tr(v, m_ctrl[31:30]), len);
            m_cnt = m_cnt + 16'd1;
            wait_idle(nb, nd, ld);
            check("busy_len", 32'(nb), 32'((len + BPC - 1) / BPC));
            check("done_pulses", 32'(nd), 32'd1);
            check("done_on_last", 32'(ld), 32'd1);
        end
    endtask

    task automatic feed_123456789();
        for (int i = 0; i < 9; i++) wr_data(32'h31 + 32'(i));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] c;
        logic [31:0] prev;
        int          nb, nd;
        logic        ld;

        m_reset();
        repeat (3) @(negedge clk);
        check("rst_data_rd", data_rd, 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;

        rd_chk("rst_poly", A_POLY, 32'h0000_1021);
        rd_chk("rst_ctrl", A_CTRL, 32'h000F_0000);
        rd_chk("rst_data", A_DATA, 32'h0000_FFFF);
        rd_chk("rst_status", A_STAT, 32'd0);
        rd_chk("unmapped_hi", BASE + 32'h10, 32'd0);
        rd_chk("unaligned", BASE + 32'h2, 32'd0);
        rd_chk("below_base", BASE - 32'h4, 32'd0);
        bus_cycle(BASE + 32'h10, 1'b1, 32'hDEAD_BEEF);
        bus_cycle(BASE + 32'h6, 1'b1, 32'hDEAD_BEEF);
        rd_chk("unmapped_wr_poly", A_POLY, 32'h0000_1021);
        rd_chk("unmapped_wr_ctrl", A_CTRL, 32'h000F_0000);

        // CRC-16/CCITT-FALSE
        wr_ctrl(32'h060F_0000);
        wr_data(32'h0000_FFFF);
        wr_ctrl(32'h000F_0000);
        feed_123456789();
        rd_chk("ccitt_false", A_DATA, 32'h0000_29B1);

        // CRC-32/MPEG-2
        wr_poly(32'h04C1_1DB7);
        wr_ctrl(32'h021F_0000);
        wr_data(32'hFFFF_FFFF);
        wr_ctrl(32'h001F_0000);
        feed_123456789();
        rd_chk("crc32_mpeg2", A_DATA, 32'h0376_E6E7);

        // CRC-32 IEEE, byte-wide reflected input
        wr_ctrl(32'h661F_0000);
        wr_data(32'hFFFF_FFFF);
        wr_ctrl(32'h641F_0000);
        feed_123456789();
        rd_chk("crc32_ieee_b", A_DATA, 32'hCBF4_3926);

        // CRC-32 IEEE, two little-endian words (full bit reversal streams byte 0 first) then one byte
        wr_ctrl(32'hA69F_0000);
        wr_data(32'hFFFF_FFFF);
        wr_ctrl(32'hA49F_0000);
        wr_data(32'h3433_3231);
        wr_data(32'h3837_3635);
        wr_ctrl(32'h641F_0000);
        wr_data(32'h0000_0039);
        rd_chk("crc32_ieee_w", A_DATA, 32'hCBF4_3926);

        // CRC-8
        wr_poly(32'h0000_0007);
        wr_ctrl(32'h0207_0000);
        wr_data(32'h0000_0000);
        wr_ctrl(32'h0007_0000);
        feed_123456789();
        rd_chk("crc8", A_DATA, 32'h0000_00F4);
        wr_poly(32'hFFFF_FF07);
        rd_chk("poly_masked", A_POLY, m_poly);
        rd_chk("status_cnt", A_STAT, m_status());

        // Dropped write and read while busy on a 32-bit word
        wr_poly(32'h04C1_1DB7);
        wr_ctrl(32'h009F_0000);
        prev = m_read_data();
        c = $urandom;
        @(negedge clk);
        sel = 1'b1; rw = 1'b1; addr = A_DATA; data_wr = c;
        @(negedge clk);
        check("drop_busy1", 32'(busy), 32'd1);
        addr = A_POLY; data_wr = 32'h1234_5678;
        @(negedge clk);
        check("drop_busy2", 32'(busy), 32'd1);
        rw = 1'b0; addr = A_DATA;
        @(negedge clk);
        sel = 1'b0;
        check("rd_busy_valid", 32'(rd_valid), 32'd1);
        check("rd_busy_prev", data_rd, prev);
        wait_idle(nb, nd, ld);
        check("drop_busy_len", 32'(nb + 2), 32'((32 + BPC - 1) / BPC));
        check("drop_done", 32'(nd), 32'd1);
        m_crc = m_crc_calc(m_crc, m_poly, m_width(m_ctrl), c, 32);
        m_cnt = m_cnt + 16'd1;
        m_ovr = 1'b1;
        rd_chk("drop_poly_kept", A_POLY, 32'h04C1_1DB7);
        rd_chk("drop_data", A_DATA, m_read_data());
        rd_chk("drop_status", A_STAT, m_status());
        bus_cycle(A_STAT, 1'b1, 32'h0000_0006);
`ifdef CRC_STATUS_EN
        m_ovr = 1'b0;
        m_cnt = 16'd0;
`endif
        rd_chk("status_clr", A_STAT, m_status());

        // Randomized configurations
        for (int it = 0; it < 30; it++) begin
            c = $urandom;
            c[25] = 1'b0;
            if ($urandom_range(0, 2) == 0) wr_poly($urandom);
            wr_ctrl(c | 32'h0200_0000);
            wr_data($urandom);
            wr_ctrl(c);
            repeat ($urandom_range(1, 4)) wr_data($urandom);
            rd_chk("rand_data", A_DATA, m_read_data());
            if (it % 6 == 0) begin
                rd_chk("rand_ctrl", A_CTRL, m_ctrl);
                rd_chk("rand_poly", A_POLY, m_poly);
                rd_chk("rand_status", A_STAT, m_status());
            end
        end

        // Reset in the middle of a word
        wr_ctrl(32'h009F_0000);
        @(negedge clk);
        sel = 1'b1; rw = 1'b1; addr = A_DATA; data_wr = $urandom;
        @(negedge clk);
        sel = 1'b0; rw = 1'b0;
        @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        rd_chk("post_rst_data", A_DATA, 32'h0000_FFFF);
        rd_chk("post_rst_ctrl", A_CTRL, 32'h000F_0000);
        rd_chk("post_rst_status", A_STAT, 32'd0);
        wr_data(32'h0000_00A5);
        rd_chk("post_rst_word", A_DATA, m_read_data());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
